// File: rtl/uart_rx_byte_if.sv
// uart_rx_byte_if
// Result bundle of the UART byte receiver, as seen by the command interpreter.
//   o_rx_byte   [7:0]  last correctly framed byte, held between strobes
//   o_new_byte         one-cycle strobe, o_rx_byte valid in the same cycle
//   o_frame_err        one-cycle strobe when a stop bit is sampled low
//   o_err_count [7:0]  saturating framing-error count
//   o_busy             receiver is inside a frame (not idle)
// Modports: master = receiver (drives everything), slave = consumer.
interface uart_rx_byte_if;
    logic [7:0] o_rx_byte;
    logic       o_new_byte;
    logic       o_frame_err;
    logic [7:0] o_err_count;
    logic       o_busy;

    modport master (
        output o_rx_byte,
        output o_new_byte,
        output o_frame_err,
        output o_err_count,
        output o_busy
    );

    modport slave (
        input o_rx_byte,
        input o_new_byte,
        input o_frame_err,
        input o_err_count,
        input o_busy
    );
endinterface

// File: rtl/uart_rx_byte.sv
// uart_rx_byte
// 8N1, LSB-first UART receiver for the raw USB-UART RX pin. The line is
// double-flopped, the start edge is confirmed at mid start bit, and each data
// and stop bit is then sampled one full bit period later (i.e. mid-bit).
// Ports:
//   i_clk    system clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   i_rx     raw serial line, idle high
//   rx_if    received byte / strobes / error count / busy (master side)
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (4..65535)
//   CNT_W         bit-timing counter width, must hold CLKS_PER_BIT-1
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 868,
    parameter int CNT_W        = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_rx,
    uart_rx_byte_if.master   rx_if
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic             rx_meta;
    logic             rx_s;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [2:0]       bit_idx, bit_idx_nx;
    logic [7:0]       shift_reg, shift_nx;
    logic [7:0]       rx_byte_q, rx_byte_nx;
    logic             new_byte_q, new_byte_nx;
    logic             frame_err_q, frame_err_nx;
    logic [7:0]       err_count_q, err_count_nx;

    // Two-flop synchronizer; resets to the idle (high) line level so a reset
    // never looks like a start edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
        end
    end

    // State and datapath registers; all next values come from the
    // combinational block below.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            bit_idx     <= 3'd0;
            shift_reg   <= 8'h00;
            rx_byte_q   <= 8'h00;
            new_byte_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_count_q <= 8'h00;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            bit_idx     <= bit_idx_nx;
            shift_reg   <= shift_nx;
            rx_byte_q   <= rx_byte_nx;
            new_byte_q  <= new_byte_nx;
            frame_err_q <= frame_err_nx;
            err_count_q <= err_count_nx;
        end
    end

    // Frame sequencing. The start bit is only half a bit long in time so that
    // every later sample lands in the middle of its bit. Returning to idle at
    // mid-stop-bit leaves half a bit of margin to catch a back-to-back start.
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        bit_idx_nx   = bit_idx;
        shift_nx     = shift_reg;
        rx_byte_nx   = rx_byte_q;
        new_byte_nx  = 1'b0;
        frame_err_nx = 1'b0;
        err_count_nx = err_count_q;

        case (state)
            S_IDLE: begin
                cnt_nx = '0;
                if (!rx_s) begin
                    state_nx = S_START;
                end
            end

            S_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_nx = '0;
                    if (!rx_s) begin
                        state_nx   = S_DATA;
                        bit_idx_nx = 3'd0;
                    end else begin
                        // Line went back high: a glitch, not a start bit.
                        state_nx = S_IDLE;
                    end
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end

            S_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_nx            = '0;
                    shift_nx[bit_idx] = rx_s;
                    if (bit_idx == 3'd7) begin
                        state_nx = S_STOP;
                    end else begin
                        bit_idx_nx = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end

            S_STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_nx = '0;
                    if (rx_s) begin
                        rx_byte_nx  = shift_reg;
                        new_byte_nx = 1'b1;
                        state_nx    = S_IDLE;
                    end else begin
                        frame_err_nx = 1'b1;
                        if (err_count_q != 8'hFF) begin
                            err_count_nx = err_count_q + 8'd1;
                        end
                        state_nx = S_BREAK;
                    end
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end

            S_BREAK: begin
                // A held-low line must not be re-read as endless 0x00 frames,
                // so wait for the line to recover before arming again.
                cnt_nx = '0;
                if (rx_s) begin
                    state_nx = S_IDLE;
                end
            end

            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    assign rx_if.o_rx_byte   = rx_byte_q;
    assign rx_if.o_new_byte  = new_byte_q;
    assign rx_if.o_frame_err = frame_err_q;
    assign rx_if.o_err_count = err_count_q;
    assign rx_if.o_busy      = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte
// Drives ideal 16-cycle UART frames into uart_rx_byte. Each frame pushes the
// outcome it should produce (good byte or framing error, with the error count
// that should then be shown) into a queue; an independent monitor pops and
// compares whenever the receiver strobes, and checks the held byte otherwise.
module tb_uart_rx_byte;

    localparam int CLKS = 16;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        logic [7:0] err_cnt;
    } exp_t;

    logic i_clk;
    logic i_rst_n;
    logic i_rx;

    uart_rx_byte_if rx_if ();

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS),
        .CNT_W        (16)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_rx    (i_rx),
        .rx_if   (rx_if)
    );

    int         total_checks = 0;
    int         bad_checks   = 0;
    int         cyc          = 0;
    exp_t       exp_q[$];
    int         pulse_cycles[$];
    logic [7:0] held_byte    = 8'h00;
    logic [7:0] model_err    = 8'h00;
    bit         prev_pulse   = 1'b0;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc++;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total_checks++;
        if (actual !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    // Sends one full frame; the expected outcome is queued first. A bad stop
    // bit is followed by extra_low more low cycles, then the line is released.
    task automatic applyStimulus(input logic [7:0] data, input bit stop_bit,
                                 input int extra_low);
        exp_t e;
        if (stop_bit) begin
            e.is_err  = 1'b0;
            e.data    = data;
            e.err_cnt = model_err;
        end else begin
            model_err = (model_err == 8'hFF) ? 8'hFF : model_err + 8'd1;
            e.is_err  = 1'b1;
            e.data    = 8'h00;
            e.err_cnt = model_err;
        end
        exp_q.push_back(e);
        i_rx = 1'b0;
        waitCycles(CLKS);
        for (int i = 0; i < 8; i++) begin
            i_rx = data[i];
            waitCycles(CLKS);
        end
        i_rx = stop_bit;
        waitCycles(CLKS);
        if (!stop_bit) begin
            waitCycles(extra_low);
            i_rx = 1'b1;
            waitCycles(4);
        end
    endtask

    task automatic applyReset(input int n);
        i_rst_n   = 1'b0;
        i_rx      = 1'b1;
        model_err = 8'h00;
        waitCycles(n);
        i_rst_n   = 1'b1;
    endtask

    // Monitor: pops one expectation per strobe; between strobes the output
    // byte must hold the last good byte.
    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            held_byte  = 8'h00;
            prev_pulse = 1'b0;
        end else begin
            if (rx_if.o_new_byte || rx_if.o_frame_err) begin
                exp_t e;
                checkOutput("pulse_exclusive",
                            32'(rx_if.o_new_byte & rx_if.o_frame_err), 32'd0);
                checkOutput("pulse_not_consecutive", 32'(prev_pulse), 32'd0);
                checkOutput("pulse_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    checkOutput("pulse_kind_is_err", 32'(rx_if.o_frame_err),
                                32'(e.is_err));
                    if (e.is_err) begin
                        checkOutput("rx_byte_kept_on_err", 32'(rx_if.o_rx_byte),
                                    32'(held_byte));
                    end else begin
                        checkOutput("rx_byte", 32'(rx_if.o_rx_byte), 32'(e.data));
                        held_byte = e.data;
                        pulse_cycles.push_back(cyc);
                    end
                    checkOutput("err_count_at_pulse", 32'(rx_if.o_err_count),
                                32'(e.err_cnt));
                end
            end else begin
                checkOutput("rx_byte_hold", 32'(rx_if.o_rx_byte), 32'(held_byte));
            end
            prev_pulse = rx_if.o_new_byte | rx_if.o_frame_err;
        end
    end

    initial begin
        int t0;
        int n;
        int lat;
        logic [7:0] d;

        i_rst_n = 1'b0;
        i_rx    = 1'b1;
        waitCycles(5);
        checkOutput("reset_rx_byte",   32'(rx_if.o_rx_byte),   32'h00);
        checkOutput("reset_new_byte",  32'(rx_if.o_new_byte),  32'd0);
        checkOutput("reset_frame_err", 32'(rx_if.o_frame_err), 32'd0);
        checkOutput("reset_err_count", 32'(rx_if.o_err_count), 32'd0);
        checkOutput("reset_busy",      32'(rx_if.o_busy),      32'd0);
        i_rst_n = 1'b1;
        waitCycles(5);

        // Single frame 'e' and its strobe latency (about 9.5 bits + sync).
        $display("[TB] single frame 0x65");
        t0 = cyc;
        n  = pulse_cycles.size();
        applyStimulus(8'h65, 1'b1, 0);
        waitCycles(20);
        checkOutput("e_pulse_count", 32'(pulse_cycles.size() - n), 32'd1);
        lat = (pulse_cycles.size() > n) ? pulse_cycles[n] - t0 : 0;
        checkOutput("e_latency_in_window", 32'(lat >= 153 && lat <= 156), 32'd1);
        checkOutput("e_rx_byte",   32'(rx_if.o_rx_byte),   32'h65);
        checkOutput("e_busy_idle", 32'(rx_if.o_busy),      32'd0);
        checkOutput("e_err_count", 32'(rx_if.o_err_count), 32'd0);

        // Back-to-back frames with no idle gap.
        $display("[TB] back-to-back 0x76 0x07");
        n = pulse_cycles.size();
        applyStimulus(8'h76, 1'b1, 0);
        applyStimulus(8'h07, 1'b1, 0);
        waitCycles(20);
        checkOutput("b2b_pulse_count", 32'(pulse_cycles.size() - n), 32'd2);
        lat = (pulse_cycles.size() >= n + 2) ?
              pulse_cycles[n+1] - pulse_cycles[n] : 0;
        checkOutput("b2b_spacing_in_window", 32'(lat >= 159 && lat <= 161), 32'd1);
        checkOutput("b2b_rx_byte", 32'(rx_if.o_rx_byte), 32'h07);

        // Short low glitch on the idle line must be ignored.
        $display("[TB] 5-cycle glitch");
        n = pulse_cycles.size();
        i_rx = 1'b0;
        waitCycles(5);
        i_rx = 1'b1;
        waitCycles(3);
        checkOutput("glitch_busy_during", 32'(rx_if.o_busy), 32'd1);
        waitCycles(30);
        checkOutput("glitch_busy_after", 32'(rx_if.o_busy),      32'd0);
        checkOutput("glitch_no_pulse",   32'(pulse_cycles.size() - n), 32'd0);
        checkOutput("glitch_rx_byte",    32'(rx_if.o_rx_byte),   32'h07);

        // Framing error followed by a 100-cycle break, from a fresh reset.
        $display("[TB] framing error and break");
        applyReset(3);
        waitCycles(5);
        applyStimulus(8'hA5, 1'b0, 100);
        waitCycles(20);
        checkOutput("ferr_err_count", 32'(rx_if.o_err_count), 32'd1);
        checkOutput("ferr_rx_byte",   32'(rx_if.o_rx_byte),   32'h00);
        checkOutput("ferr_busy",      32'(rx_if.o_busy),      32'd0);
        applyStimulus(8'h31, 1'b1, 0);
        waitCycles(20);
        checkOutput("after_ferr_rx_byte", 32'(rx_if.o_rx_byte), 32'h31);

        // Reset during data bit 4 of 0x5A, then a clean 0x3C.
        $display("[TB] reset mid-frame");
        d = 8'h5A;
        n = pulse_cycles.size();
        i_rx = 1'b0;
        waitCycles(CLKS);
        for (int i = 0; i < 4; i++) begin
            i_rx = d[i];
            waitCycles(CLKS);
        end
        i_rx = d[4];
        waitCycles(CLKS / 2);
        applyReset(2);
        checkOutput("abort_rx_byte_cleared", 32'(rx_if.o_rx_byte), 32'h00);
        waitCycles(5);
        applyStimulus(8'h3C, 1'b1, 0);
        waitCycles(20);
        checkOutput("abort_pulse_count", 32'(pulse_cycles.size() - n), 32'd1);
        checkOutput("abort_rx_byte",     32'(rx_if.o_rx_byte),   32'h3C);
        checkOutput("abort_err_count",   32'(rx_if.o_err_count), 32'd0);

        // Random good frames with random idle gaps (including none).
        $display("[TB] random frames");
        for (int k = 0; k < 10; k++) begin
            applyStimulus(8'($urandom), 1'b1, 0);
            waitCycles($urandom_range(0, 10));
        end
        waitCycles(20);

        // Error counter saturation, then a good frame still gets through.
        $display("[TB] error count saturation");
        for (int k = 0; k < 260; k++) begin
            applyStimulus(8'($urandom), 1'b0, $urandom_range(0, 8));
        end
        waitCycles(10);
        checkOutput("sat_err_count", 32'(rx_if.o_err_count), 32'hFF);
        applyStimulus(8'h66, 1'b1, 0);
        waitCycles(20);
        checkOutput("sat_rx_byte",        32'(rx_if.o_rx_byte),   32'h66);
        checkOutput("sat_err_count_hold", 32'(rx_if.o_err_count), 32'hFF);

        waitCycles(40);
        checkOutput("all_expected_pulses_seen", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
- Serial UART receiver that turns the raw Basys3 USB-UART RX pin into bytes with a one-cycle valid strobe.
- Feeds the command interpreter directly: o_rx_byte drives its i_rx_byte and o_new_byte drives its i_new_byte.
- Fixed frame format 8N1, LSB first. Mid-bit sampling driven by a per-bit clock-cycle counter.
- Also reports framing errors and keeps a saturating error count for debug LEDs.

Parameters:
- CLKS_PER_BIT, 868, i_clk cycles per UART bit (100 MHz / 115200); legal range 4..65535.
- CNT_W, 16, width of the bit-timing counter; must hold CLKS_PER_BIT-1.

Ports:
- i_clk  input  1  system clock, all logic on rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_rx  input  1  raw asynchronous serial line; idle high.
- o_rx_byte  output  8  last correctly framed byte; holds its value between strobes.
- o_new_byte  output  1  single-cycle pulse; o_rx_byte is valid in the same cycle.
- o_frame_err  output  1  single-cycle pulse when the stop bit is sampled low.
- o_err_count  output  8  saturating count of framing errors.
- o_busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, both synchronizer flops=1, counter=0, bit index=0, o_rx_byte=0x00, o_new_byte=0, o_frame_err=0, o_err_count=0, o_busy=0.
- Synchronizer: i_rx passes through two flops to give rx_s. All FSM decisions use rx_s only.
- IDLE:
  - Counter held at 0.
  - rx_s==0 moves to START with counter=0.
- START:
  - Counter increments each cycle.
  - At counter==(CLKS_PER_BIT/2)-1 (integer division): if rx_s==0, go to DATA with counter=0 and bit index=0.
  - If rx_s==1 at that point, treat it as a glitch: return to IDLE with no output.
- DATA:
  - Counter increments each cycle.
  - At counter==CLKS_PER_BIT-1: shift_reg[bit index]<=rx_s and counter=0.
  - If bit index==7, go to STOP; otherwise increment bit index.
- STOP:
  - At counter==CLKS_PER_BIT-1:
    - rx_s==1: o_rx_byte<=shift_reg, o_new_byte=1 for exactly one cycle, go to IDLE.
    - rx_s==0: o_frame_err=1 for one cycle, o_err_count increments (holds at 255), o_rx_byte unchanged, no o_new_byte, go to BREAK.
- BREAK: wait until rx_s==1, then go to IDLE. A held-low line (break) produces exactly one error, not repeated frames.
- Strobe timing: the o_new_byte rising edge occurs 9.5*CLKS_PER_BIT + 2..3 cycles after the i_rx falling edge of the start bit (±1 for synchronizer phase).
- Back-to-back frames: return to IDLE at mid-stop-bit, so the next start edge is caught with no lost frame. Each frame yields one pulse.
- o_new_byte and o_frame_err are mutually exclusive and never asserted in consecutive cycles.
- Reset mid-frame discards the partial byte. After release, the receiver waits in IDLE for the next falling edge. If the line is low at release, the remainder of that frame is received as garbage and normally ends in BREAK/frame_err; this is accepted.
- shift_reg is not reset-visible. Only o_rx_byte is architecturally defined.

Test Plan:
- All scenarios run with CLKS_PER_BIT=16. The bench drives i_rx with ideal 16-cycle bits.
- Reset then send 0x65 ('e') → exactly one o_new_byte pulse, o_rx_byte=0x65, o_frame_err never high, o_busy low afterwards, o_err_count=0.
- Back-to-back 'v' (0x76) then 0x07 with no idle gap → two pulses 160 cycles apart (±1), carrying 0x76 and then 0x07; the held o_rx_byte between pulses equals the previous byte.
- Low glitch of 5 cycles on the idle line → FSM returns to IDLE, no o_new_byte, no o_frame_err, o_rx_byte unchanged.
- Frame 0xA5 with stop bit driven 0, then line held low for 100 cycles before returning high → one o_frame_err pulse, o_err_count=1, o_rx_byte keeps its prior value (0x00 after reset). Then send 0x31 → o_rx_byte=0x31.
- Assert i_rst_n low during data bit 4 of 0x5A, release for 2 cycles, then send 0x3C → no pulse for the aborted frame, one pulse with 0x3C, o_err_count=0.
- 260 consecutive frames with bad stop bits → o_err_count saturates at 255 and stays there; a following good frame 0x66 still produces a pulse with 0x66.
